// File: rtl/irig_pwm_decoder.sv
// IRIG-B pulse-width decoder: measures high pulses, classifies them as
// zero/one/marker/error, and tracks frame alignment and the 0..99 bit position.
module irig_pwm_decoder #(
  parameter int MS_TICKS = 1000,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irig_d0,
  output logic       sym_valid,
  output logic [1:0] sym_code,
  output logic       frame_start,
  output logic [6:0] bit_index,
  output logic       locked
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_ONE  = 2'b01;
  localparam logic [1:0] SYM_MARK = 2'b10;
  localparam logic [1:0] SYM_ERR  = 2'b11;

  localparam logic [CNT_W:0]   T_ZERO = (CNT_W+1)'(MS_TICKS);
  localparam logic [CNT_W:0]   T_ONE  = (CNT_W+1)'(7  * MS_TICKS / 2);
  localparam logic [CNT_W:0]   T_MARK = (CNT_W+1)'(13 * MS_TICKS / 2);
  localparam logic [CNT_W:0]   T_ERR  = (CNT_W+1)'(19 * MS_TICKS / 2);
  localparam logic [CNT_W-1:0] T_LOS  = CNT_W'(12 * MS_TICKS);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             prev_mk;

  logic             emit, rise, los;
  logic [CNT_W:0]   width;
  logic [1:0]       code;
  logic             is_mk, exp_mk;
  logic [6:0]       nxt_idx;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!irig_d0) state_nxt = LOW;
      LOW:     if (irig_d0)  state_nxt = HIGH;
      HIGH:    if (!irig_d0) state_nxt = LOW;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded actions; a rise wins over a simultaneous timeout
  always_comb begin
    emit = (state == HIGH) && !irig_d0;
    rise = (state == LOW)  &&  irig_d0;
    los  = (state == LOW)  && !irig_d0 && (cnt > T_LOS);
  end

  // The rising edge that leaves LOW already sampled a 1, so W = cnt + 1.
  always_comb begin
    width = {1'b0, cnt} + 1'b1;
    if (&cnt)                code = SYM_ERR;
    else if (width < T_ZERO) code = SYM_ERR;
    else if (width < T_ONE)  code = SYM_ZERO;
    else if (width < T_MARK) code = SYM_ONE;
    else if (width < T_ERR)  code = SYM_MARK;
    else                     code = SYM_ERR;
    is_mk   = (code == SYM_MARK);
    nxt_idx = (bit_index == 7'd99) ? 7'd0 : bit_index + 7'd1;
    exp_mk  = ((nxt_idx % 7'd10) == 7'd9);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case (state)
        LOW:     cnt <= rise ? '0 : ((&cnt) ? cnt : cnt + 1'b1);
        HIGH:    cnt <= emit ? '0 : ((&cnt) ? cnt : cnt + 1'b1);
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_valid   <= 1'b0;
      sym_code    <= SYM_ZERO;
      frame_start <= 1'b0;
      bit_index   <= '0;
      locked      <= 1'b0;
      prev_mk     <= 1'b0;
    end else begin
      sym_valid   <= 1'b0;
      frame_start <= 1'b0;
      if (emit) begin
        sym_valid <= 1'b1;
        sym_code  <= code;
        prev_mk   <= is_mk;
        if (is_mk && prev_mk) begin
          frame_start <= 1'b1;
          bit_index   <= '0;
          locked      <= 1'b1;
        end else if (locked) begin
          // any position or error inconsistency drops alignment
          if ((code == SYM_ERR) || (is_mk != exp_mk)) begin
            locked    <= 1'b0;
            bit_index <= '0;
          end else begin
            bit_index <= nxt_idx;
          end
        end
      end
      if (los) begin
        locked    <= 1'b0;
        prev_mk   <= 1'b0;
        bit_index <= '0;
      end
    end
  end

endmodule

// File: tb/tb_irig_pwm_decoder.sv
// Directed bench for irig_pwm_decoder at MS_TICKS=10: classification,
// boundaries, frame lock/relock, loss-of-signal and mid-pulse reset.
module tb_irig_pwm_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       irig_d0;
  logic       sym_valid;
  logic [1:0] sym_code;
  logic       frame_start;
  logic [6:0] bit_index;
  logic       locked;

  irig_pwm_decoder #(.MS_TICKS(10), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .irig_d0(irig_d0),
    .sym_valid(sym_valid), .sym_code(sym_code), .frame_start(frame_start),
    .bit_index(bit_index), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] code;
    logic       fs;
    logic [6:0] idx;
    logic       lk;
    int         cyc;
  } sym_t;

  sym_t q[$];
  int   cyc = 0;
  int   fall_cyc = 0;
  int   dbl = 0;
  int   orphan_fs = 0;
  logic prev_sv = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sym_valid) begin
      q.push_back('{sym_code, frame_start, bit_index, locked, cyc});
      if (prev_sv) dbl <= dbl + 1;
    end
    if (frame_start && !sym_valid) orphan_fs <= orphan_fs + 1;
    prev_sv <= sym_valid;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    irig_d0 = 1'b1;
    repeat (hi) @(posedge clk);
    #1 irig_d0 = 1'b0;
    fall_cyc = cyc;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  // expected packed as {code, fs, idx, lk}
  task automatic pop(input string tag, input int code, input int fs, input int idx, input int lk);
    sym_t s;
    if (q.size() == 0) begin
      chk({tag, "_missing"}, 0, 1);
    end else begin
      s = q.pop_front();
      chk(tag, {s.code, s.fs, s.idx, s.lk}, {code[1:0], fs[0], idx[6:0], lk[0]});
    end
  endtask

  function automatic int hi_of(input int c);
    return (c == 0) ? 20 : (c == 1) ? 50 : 80;
  endfunction

  int bw[8]   = '{9, 10, 34, 35, 64, 65, 94, 95};
  int bexp[8] = '{3, 0, 0, 1, 1, 2, 2, 3};

  initial begin
    sym_t s;
    int   c;
    rst_n   = 1'b0;
    irig_d0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {sym_valid, sym_code, frame_start, bit_index, locked}, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // basic classes and latency
    pulse(20, 80);
    if (q.size() > 0) chk("latency", q[0].cyc, fall_cyc + 1);
    else              chk("latency_missing", 0, 1);
    pop("cls_zero", 0, 0, 0, 0);
    chk("one_per_pulse0", q.size(), 0);
    pulse(50, 50);
    pop("cls_one", 1, 0, 0, 0);
    chk("one_per_pulse1", q.size(), 0);
    pulse(80, 20);
    pop("cls_mark", 2, 0, 0, 0);
    chk("one_per_pulse2", q.size(), 0);

    // boundaries; 65 then 94 form a marker pair, 95 then unlocks
    pulse(bw[0], 20);
    if (q.size() > 0) begin s = q.pop_front(); chk("bnd_9", s.code, bexp[0]); end
    else chk("bnd_9_missing", 0, 1);
    for (int i = 1; i < 8; i++) begin
      pulse(bw[i], 20);
      if (q.size() > 0) begin s = q.pop_front(); chk($sformatf("bnd_%0d", bw[i]), s.code, bexp[i]); end
      else chk($sformatf("bnd_%0d_missing", bw[i]), 0, 1);
    end
    chk("bnd_unlock", locked, 0);

    // full frame
    pulse(80, 20);
    pop("ff_m1", 2, 0, 0, 0);
    pulse(80, 20);
    pop("ff_m2", 2, 1, 0, 1);
    for (int i = 1; i < 100; i++) begin
      c = (i % 10 == 9) ? 2 : (i % 2);
      pulse(hi_of(c), 100 - hi_of(c));
      pop($sformatf("ff_i%0d", i), c, 0, i, 1);
    end
    pulse(80, 20);
    pop("ff_wrap", 2, 1, 0, 1);

    // missing marker at 39
    for (int i = 1; i < 39; i++) begin
      c = (i % 10 == 9) ? 2 : (i % 2);
      pulse(hi_of(c), 100 - hi_of(c));
      pop($sformatf("mm_i%0d", i), c, 0, i, 1);
    end
    pulse(50, 50);
    pop("mm_drop", 1, 0, 0, 0);
    pulse(80, 20);
    pop("relock_m1", 2, 0, 0, 0);
    pulse(80, 20);
    pop("relock_m2", 2, 1, 0, 1);

    // loss of signal: 20 + 105 = 125 low cycles
    repeat (105) @(posedge clk);
    #1;
    chk("los_locked", locked, 0);
    chk("los_nosym", q.size(), 0);
    pulse(50, 50);
    pop("los_after", 1, 0, 0, 0);

    // reset mid-pulse, input still high at release
    irig_d0 = 1'b1;
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_outs", {sym_valid, sym_code, frame_start, bit_index, locked}, 0);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1 irig_d0 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_nosym", q.size(), 0);
    chk("midrst_hold", {sym_valid, sym_code, frame_start, bit_index, locked}, 0);
    pulse(20, 20);
    pop("midrst_first", 0, 0, 0, 0);

    chk("dbl_strobe", dbl, 0);
    chk("orphan_fs", orphan_fs, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
